// File: rtl/reuleaux_ctrl_if.sv
// Circle-engine bus: arc request (centre, radius, colour, clip window) out,
// engine pixel stream back in.
interface reuleaux_ctrl_if;
  // Handshake: circ_start is a level request held high while an arc is wanted
  // and all arc fields are stable while it is high; the engine raises circ_done
  // when the arc is drawn, the controller drops circ_start on the next cycle and
  // waits for circ_done to fall before issuing the next request.
  logic       circ_start;
  logic       circ_done;
  logic [9:0] circ_centre_x;
  logic [9:0] circ_centre_y;
  logic [7:0] circ_radius;
  logic [2:0] circ_colour;
  logic [7:0] clip_x_lo;
  logic [7:0] clip_x_hi;
  logic [6:0] clip_y_lo;
  logic [6:0] clip_y_hi;
  logic [7:0] circ_vga_x;
  logic [6:0] circ_vga_y;
  logic [2:0] circ_vga_colour;
  logic       circ_vga_plot;

  modport master (
    output circ_start, circ_centre_x, circ_centre_y, circ_radius, circ_colour,
           clip_x_lo, clip_x_hi, clip_y_lo, clip_y_hi,
    input  circ_done, circ_vga_x, circ_vga_y, circ_vga_colour, circ_vga_plot
  );

  modport slave (
    input  circ_start, circ_centre_x, circ_centre_y, circ_radius, circ_colour,
           clip_x_lo, clip_x_hi, clip_y_lo, clip_y_hi,
    output circ_done, circ_vga_x, circ_vga_y, circ_vga_colour, circ_vga_plot
  );
endinterface

// File: rtl/reuleaux_ctrl.sv
// Reuleaux triangle sequencer: optional screen clear, then three clipped
// arcs of radius d handed one at a time to an external circle engine.
module reuleaux_ctrl #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear_en,
  input  logic [2:0]        colour,
  input  logic [7:0]        centre_x,
  input  logic [6:0]        centre_y,
  input  logic [7:0]        diameter,
  output logic              done,
  reuleaux_ctrl_if.master   circ,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ARC_RUN = 3'd2,
    S_ARC_GAP = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [7:0]        X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0]        Y_LAST = 7'(SCR_H - 1);
  localparam logic signed [9:0] X_MAX  = 10'(SCR_W - 1);
  localparam logic signed [9:0] Y_MAX  = 10'(SCR_H - 1);

  state_t     state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [7:0] clr_x, clr_x_nxt;
  logic [6:0] clr_y, clr_y_nxt;
  logic [7:0] cx_q, d_q;
  logic [6:0] cy_q;
  logic [2:0] col_q;
  logic       arc_load;

  always_comb begin
    state_nxt       = state;
    k_nxt           = k;
    clr_x_nxt       = clr_x;
    clr_y_nxt       = clr_y;
    done            = 1'b0;
    circ.circ_start = 1'b0;
    vga_x           = '0;
    vga_y           = '0;
    vga_colour      = '0;
    vga_plot        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          k_nxt     = 2'd0;
          clr_x_nxt = '0;
          clr_y_nxt = '0;
          state_nxt = clear_en ? S_CLEAR : S_ARC_RUN;
        end
      end
      S_CLEAR: begin
        vga_x    = clr_x;
        vga_y    = clr_y;
        vga_plot = 1'b1;
        if (clr_y == Y_LAST) begin
          clr_y_nxt = '0;
          if (clr_x == X_LAST) begin
            clr_x_nxt = '0;
            state_nxt = S_ARC_RUN;
          end else begin
            clr_x_nxt = clr_x + 8'd1;
          end
        end else begin
          clr_y_nxt = clr_y + 7'd1;
        end
      end
      S_ARC_RUN: begin
        circ.circ_start = 1'b1;
        vga_x      = circ.circ_vga_x;
        vga_y      = circ.circ_vga_y;
        vga_colour = circ.circ_vga_colour;
        vga_plot   = circ.circ_vga_plot;
        if (circ.circ_done) state_nxt = S_ARC_GAP;
      end
      S_ARC_GAP: begin
        vga_x      = circ.circ_vga_x;
        vga_y      = circ.circ_vga_y;
        vga_colour = circ.circ_vga_colour;
        vga_plot   = circ.circ_vga_plot;
        if (!circ.circ_done) begin
          if (k == 2'd2) begin
            state_nxt = S_FINISH;
          end else begin
            k_nxt     = k + 2'd1;
            state_nxt = S_ARC_RUN;
          end
        end
      end
      S_FINISH: begin
        done = 1'b1;
        if (!start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Geometry is evaluated on the edge that enters ARC_RUN; from IDLE the
  // operands are being latched on that same edge, so take them from the ports.
  logic [7:0]        src_cx, src_d;
  logic [6:0]        src_cy;
  logic [2:0]        src_col;
  logic [13:0]       d37;
  logic signed [9:0] cx_s, cy_s, ht, hb, hf, ty, by, lx, rx;
  logic signed [9:0] ac_x, ac_y, xl, xh, yl, yh;

  assign src_cx  = (state == S_IDLE) ? centre_x : cx_q;
  assign src_cy  = (state == S_IDLE) ? centre_y : cy_q;
  assign src_d   = (state == S_IDLE) ? diameter : d_q;
  assign src_col = (state == S_IDLE) ? colour   : col_q;

  always_comb begin
    d37  = 14'(src_d) * 14'd37;
    ht   = {2'b00, d37[13:6]};
    hb   = {3'b000, d37[13:7]};
    hf   = {3'b000, src_d[7:1]};
    cx_s = {2'b00, src_cx};
    cy_s = {3'b000, src_cy};
    ty   = cy_s - ht;
    by   = cy_s + hb;
    lx   = cx_s - hf;
    rx   = cx_s + hf;
  end

  always_comb begin
    ac_x = cx_s; ac_y = ty; xl = lx; xh = rx; yl = by; yh = Y_MAX;
    case (k_nxt)
      2'd1:    begin ac_x = lx; ac_y = by; xl = cx_s; xh = rx;   yl = ty; yh = by; end
      2'd2:    begin ac_x = rx; ac_y = by; xl = lx;   xh = cx_s; yl = ty; yh = by; end
      default: ;
    endcase
  end

  function automatic logic [7:0] sat_x(input logic signed [9:0] v);
    if (v < 10'sd0)      sat_x = '0;
    else if (v > X_MAX)  sat_x = X_LAST;
    else                 sat_x = v[7:0];
  endfunction

  function automatic logic [6:0] sat_y(input logic signed [9:0] v);
    if (v < 10'sd0)      sat_y = '0;
    else if (v > Y_MAX)  sat_y = Y_LAST;
    else                 sat_y = v[6:0];
  endfunction

  assign arc_load  = (state_nxt == S_ARC_RUN) && (state != S_ARC_RUN);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      k                  <= '0;
      clr_x              <= '0;
      clr_y              <= '0;
      cx_q               <= '0;
      cy_q               <= '0;
      d_q                <= '0;
      col_q              <= '0;
      circ.circ_centre_x <= '0;
      circ.circ_centre_y <= '0;
      circ.circ_radius   <= '0;
      circ.circ_colour   <= '0;
      circ.clip_x_lo     <= '0;
      circ.clip_x_hi     <= '0;
      circ.clip_y_lo     <= '0;
      circ.clip_y_hi     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      clr_x <= clr_x_nxt;
      clr_y <= clr_y_nxt;
      if (state == S_IDLE && start) begin
        cx_q  <= centre_x;
        cy_q  <= centre_y;
        d_q   <= diameter;
        col_q <= colour;
      end
      if (arc_load) begin
        circ.circ_centre_x <= ac_x;
        circ.circ_centre_y <= ac_y;
        circ.circ_radius   <= src_d;
        circ.circ_colour   <= src_col;
        circ.clip_x_lo     <= sat_x(xl);
        circ.clip_x_hi     <= sat_x(xh);
        circ.clip_y_lo     <= sat_y(yl);
        circ.clip_y_hi     <= sat_y(yh);
      end
    end
  end

endmodule

// File: tb/tb_reuleaux_ctrl.sv
// Bench for reuleaux_ctrl: table of hand-computed arc parameters per job,
// plus directed sequences for clear scan, reset mid-clear and held start.
module tb_reuleaux_ctrl;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clear_en = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] diameter = '0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [2:0] dbg_state;

  reuleaux_ctrl_if circ_bus();

  reuleaux_ctrl #(.SCR_W(160), .SCR_H(120)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en),
    .colour(colour), .centre_x(centre_x), .centre_y(centre_y),
    .diameter(diameter), .done(done), .circ(circ_bus.master),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rises    = 0;
  logic prev_cs = 1'b0;

  always @(posedge clk) begin
    prev_cs <= circ_bus.circ_start;
    if (circ_bus.circ_start && !prev_cs) rises <= rises + 1;
  end

  typedef struct {
    bit clr; bit hold; int col; int cx; int cy; int d; int k;
    int ecx; int ecy; int xlo; int xhi; int ylo; int yhi;
  } arc_vec_t;

  arc_vec_t   vecs[9];
  logic [14:0] exp_q[$];
  int         rises_at_job;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_arc_fields(input arc_vec_t v, input string tag);
    check({tag, "_cx"},   int'($signed(circ_bus.circ_centre_x)), v.ecx);
    check({tag, "_cy"},   int'($signed(circ_bus.circ_centre_y)), v.ecy);
    check({tag, "_r"},    int'(circ_bus.circ_radius), v.d);
    check({tag, "_col"},  int'(circ_bus.circ_colour), v.col);
    check({tag, "_xlo"},  int'(circ_bus.clip_x_lo), v.xlo);
    check({tag, "_xhi"},  int'(circ_bus.clip_x_hi), v.xhi);
    check({tag, "_ylo"},  int'(circ_bus.clip_y_lo), v.ylo);
    check({tag, "_yhi"},  int'(circ_bus.clip_y_hi), v.yhi);
  endtask

  // driver: called at a negedge with the DUT idle
  task automatic launch_job(input arc_vec_t v);
    rises_at_job = rises;
    centre_x = 8'(v.cx); centre_y = 7'(v.cy); diameter = 8'(v.d);
    colour = 3'(v.col); clear_en = v.clr; start = 1'b1;
    @(negedge clk);
    if (!v.hold) start = 1'b0;
    centre_x = ~centre_x; centre_y = ~centre_y; diameter = ~diameter;
    colour = ~colour; clear_en = ~clear_en;
  endtask

  task automatic clear_scan();
    int errs = 0;
    logic [14:0] e;
    for (int i = 0; i < 19200; i++) exp_q.push_back({8'(i / 120), 7'(i % 120)});
    for (int i = 0; i < 19200; i++) begin
      e = exp_q.pop_front();
      if (!vga_plot || vga_colour != 3'd0 || dbg_state != ST_CLEAR ||
          {vga_x, vga_y} != e) errs++;
      @(negedge clk);
    end
    check("clear_scan_errors", errs, 0);
    check("clear_then_circ_start", int'(circ_bus.circ_start), 1);
    check("clear_then_state_run", int'(dbg_state), int'(ST_RUN));
  endtask

  task automatic run_arc(input arc_vec_t v);
    int w = 0;
    int stab = 0;
    int gap = 0;
    int held = 1;
    int gap_err = 0;
    string tag;
    tag = $sformatf("job%0d_%0d_%0d_arc%0d", v.cx, v.cy, v.d, v.k);
    while (!circ_bus.circ_start && w < 40) begin @(negedge clk); w++; end
    check({tag, "_start_seen"}, int'(circ_bus.circ_start), 1);
    check_arc_fields(v, tag);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (int'($signed(circ_bus.circ_centre_x)) != v.ecx ||
          int'($signed(circ_bus.circ_centre_y)) != v.ecy ||
          int'(circ_bus.clip_x_lo) != v.xlo || int'(circ_bus.clip_y_hi) != v.yhi ||
          !circ_bus.circ_start) stab++;
    end
    check({tag, "_stable"}, stab, 0);
    circ_bus.circ_vga_x = 8'(17 + v.k * 40); circ_bus.circ_vga_y = 7'(9 + v.k * 30);
    circ_bus.circ_vga_colour = 3'(v.col); circ_bus.circ_vga_plot = 1'b1;
    #1;
    check({tag, "_pass_x"}, int'(vga_x), 17 + v.k * 40);
    check({tag, "_pass_y"}, int'(vga_y), 9 + v.k * 30);
    check({tag, "_pass_plot"}, int'(vga_plot), 1);
    circ_bus.circ_done = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dbg_state != ST_GAP) break;
      gap++;
      if (circ_bus.circ_start || vga_x != circ_bus.circ_vga_x) gap_err++;
      if (held < 3) held++;
      else circ_bus.circ_done = 1'b0;
    end
    circ_bus.circ_done = 1'b0;
    circ_bus.circ_vga_plot = 1'b0;
    check({tag, "_gap_len"}, gap, 3);
    check({tag, "_gap_err"}, gap_err, 0);
  endtask

  task automatic finish_job(input arc_vec_t v);
    check("finish_state", int'(dbg_state), int'(ST_FIN));
    check("finish_done", int'(done), 1);
    check("finish_vga_plot", int'(vga_plot), 0);
    check("finish_vga_xy", int'({vga_x, vga_y, vga_colour}), 0);
    check("circ_start_rises", rises - rises_at_job, 3);
    if (v.hold) begin
      int bad = 0;
      circ_bus.circ_done = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (!done || dbg_state != ST_FIN || circ_bus.circ_start) bad++;
      end
      circ_bus.circ_done = 1'b0;
      check("held_start_stays_finish", bad, 0);
      start = 1'b0;
    end
    @(negedge clk);
    check("after_finish_state", int'(dbg_state), int'(ST_IDLE));
    check("after_finish_done", int'(done), 0);
  endtask

  initial begin
    circ_bus.circ_done = 1'b0;
    circ_bus.circ_vga_x = '0; circ_bus.circ_vga_y = '0;
    circ_bus.circ_vga_colour = '0; circ_bus.circ_vga_plot = 1'b0;

    //  clr hold col  cx  cy   d  k  ecx  ecy  xlo xhi ylo yhi
    vecs[0] = '{1, 0, 5,  80, 60,  40, 0,  80,  37,  60, 100, 71, 119};
    vecs[1] = '{1, 0, 5,  80, 60,  40, 1,  60,  71,  80, 100, 37,  71};
    vecs[2] = '{1, 0, 5,  80, 60,  40, 2, 100,  71,  60,  80, 37,  71};
    vecs[3] = '{0, 0, 2,   5,  5,  80, 0,   5, -41,   0,  45, 28, 119};
    vecs[4] = '{0, 0, 2,   5,  5,  80, 1, -35,  28,   5,  45,  0,  28};
    vecs[5] = '{0, 0, 2,   5,  5,  80, 2,  45,  28,   0,   5,  0,  28};
    vecs[6] = '{0, 1, 7, 150, 110, 200, 0, 150,  -5,  50, 159, 119, 119};
    vecs[7] = '{0, 1, 7, 150, 110, 200, 1,  50, 167, 150, 159,  0, 119};
    vecs[8] = '{0, 1, 7, 150, 110, 200, 2, 250, 167,  50, 150,  0, 119};

    repeat (3) @(negedge clk);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    check("rst_done", int'(done), 0);
    check("rst_circ_start", int'(circ_bus.circ_start), 0);
    check("rst_vga_plot", int'(vga_plot), 0);
    check("rst_circ_regs", int'(circ_bus.circ_radius) + int'(circ_bus.circ_centre_x) +
          int'(circ_bus.clip_x_hi) + int'(circ_bus.clip_y_hi), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", int'(dbg_state), int'(ST_IDLE));
    check("post_rst_vga", int'({vga_plot, vga_x, vga_y, vga_colour}), 0);

    circ_bus.circ_done = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ignores_circ_done", int'(dbg_state), int'(ST_IDLE));
    check("idle_no_circ_start", int'(circ_bus.circ_start), 0);
    circ_bus.circ_done = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].k == 0) begin
        launch_job(vecs[i]);
        if (vecs[i].clr) clear_scan();
      end
      run_arc(vecs[i]);
      if (vecs[i].k == 2) finish_job(vecs[i]);
    end

    // reset in the middle of a clear, then a fresh clear from (0,0)
    launch_job('{1, 0, 1, 40, 40, 20, 0, 0, 0, 0, 0, 0, 0});
    repeat (500) @(negedge clk);
    check("pix500_x", int'(vga_x), 4);
    check("pix500_y", int'(vga_y), 20);
    rst_n = 1'b0;
    @(negedge clk);
    check("midclr_rst_plot", int'(vga_plot), 0);
    check("midclr_rst_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("midclr_rst_radius", int'(circ_bus.circ_radius), 0);
    launch_job('{1, 0, 1, 40, 40, 20, 0, 0, 0, 0, 0, 0, 0});
    check("restart_first_xy", int'({vga_x, vga_y}), 0);
    check("restart_plot", int'(vga_plot), 1);
    @(negedge clk);
    check("restart_second_y", int'(vga_y), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
